// File: rtl/cordic_iter_param.sv
// -----------------------------------------------------------------------------
// cordic_iter_param
// Iterative CORDIC engine covering circular, linear and hyperbolic geometry in
// both rotation and vectoring form. Each accepted command preloads x/y/z and
// then runs ITER micro-steps, one per clock. The final values are saturated to
// WIDTH bits and presented with a one-cycle done pulse.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          command request; only accepted in IDLE
//   mode[2:0]      0 circ-rot, 1 circ-vec, 2 lin-rot, 3 lin-vec,
//                  4 hyp-rot, 5 hyp-vec, 6/7 illegal
//   x_in/y_in/z_in signed Q(WIDTH-FRAC).FRAC operands, z in radians
//   busy           high from the cycle after acceptance until done
//   done           one-cycle completion pulse
//   err            set with done when the mode was illegal
//   ovf            set with done when any result saturated
//   x_out/y_out/z_out  signed results, held until the next completion
// -----------------------------------------------------------------------------
module cordic_iter_param #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ovf,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    localparam int IW     = WIDTH + GUARD;
    localparam int RND_SH = 32 - FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Geometry is encoded in mode[2:1]; mode[0] selects vectoring.
    localparam logic [1:0] GEO_CIRC = 2'b00;
    localparam logic [1:0] GEO_LIN  = 2'b01;
    localparam logic [1:0] GEO_HYP  = 2'b10;

    // atan(2^-s) scaled by 2^32. For s >= 11 the value rounds to 2^(32-s).
    function automatic logic [63:0] atan_rom32(input logic [4:0] s);
        logic [63:0] v;
        case (s)
            5'd0:    v = 64'd3373259426;
            5'd1:    v = 64'd1991351318;
            5'd2:    v = 64'd1052175346;
            5'd3:    v = 64'd534100635;
            5'd4:    v = 64'd268086748;
            5'd5:    v = 64'd134174063;
            5'd6:    v = 64'd67103403;
            5'd7:    v = 64'd33553749;
            5'd8:    v = 64'd16777131;
            5'd9:    v = 64'd8388597;
            5'd10:   v = 64'd4194303;
            5'd31:   v = 64'd0;
            default: v = 64'd1 << (6'd32 - {1'b0, s});
        endcase
        return v;
    endfunction

    // atanh(2^-s) scaled by 2^32. Entry 0 (atanh(1)) is unbounded and never
    // addressed because hyperbolic shifts start at 1.
    function automatic logic [63:0] atanh_rom32(input logic [4:0] s);
        logic [63:0] v;
        case (s)
            5'd0:    v = 64'd0;
            5'd1:    v = 64'd2359251925;
            5'd2:    v = 64'd1096989674;
            5'd3:    v = 64'd539693625;
            5'd4:    v = 64'd268785803;
            5'd5:    v = 64'd134261444;
            5'd6:    v = 64'd67114326;
            5'd7:    v = 64'd33555115;
            5'd8:    v = 64'd16777301;
            5'd9:    v = 64'd8388619;
            5'd10:   v = 64'd4194305;
            5'd31:   v = 64'd0;
            default: v = 64'd1 << (6'd32 - {1'b0, s});
        endcase
        return v;
    endfunction

    // 2^-s scaled by 2^32.
    function automatic logic [63:0] lin_rom32(input logic [4:0] s);
        logic [63:0] v;
        if (s == 5'd31) begin
            v = 64'd0;
        end else begin
            v = 64'd1 << (6'd32 - {1'b0, s});
        end
        return v;
    endfunction

    // Round-half-up from 32 fraction bits down to FRAC fraction bits.
    function automatic logic [63:0] to_frac(input logic [63:0] v);
        return (v + (64'd1 << (RND_SH - 1))) >> RND_SH;
    endfunction

    // True when the guard bits plus the WIDTH sign bit are not all equal.
    function automatic logic out_of_range(input logic signed [IW-1:0] v);
        logic [GUARD:0] top;
        top = v[IW-1:WIDTH-1];
        return (top != {(GUARD+1){1'b0}}) && (top != {(GUARD+1){1'b1}});
    endfunction

    // Clamp an internal value to the signed WIDTH-bit range.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [IW-1:0] v);
        logic signed [WIDTH-1:0] r;
        if (!out_of_range(v)) begin
            r = v[WIDTH-1:0];
        end else if (v[IW-1]) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Constant tables, reduced to FRAC at elaboration. Index 31 is unreachable.
    logic [IW-1:0] e_circ_s [0:31];
    logic [IW-1:0] e_lin_s  [0:31];
    logic [IW-1:0] e_hyp_s  [0:31];

    for (genvar g = 0; g < 32; g++) begin : g_rom
        assign e_circ_s[g] = IW'(to_frac(atan_rom32(5'(g))));
        assign e_lin_s[g]  = IW'(to_frac(lin_rom32(5'(g))));
        assign e_hyp_s[g]  = IW'(to_frac(atanh_rom32(5'(g))));
    end

    state_t               state_r;
    logic [2:0]           mode_r;
    logic                 illegal_r;
    logic signed [IW-1:0] x_r, y_r, z_r;
    logic [4:0]           k_r;
    logic [4:0]           shift_r;
    logic                 rep_r;

    logic signed [IW-1:0] xs_s, ys_s, e_s;
    logic signed [IW-1:0] x_nxt_s, y_nxt_s, z_nxt_s;
    logic                 dir_neg_s;
    logic                 hyp_repeat_s;

    // One CORDIC micro-step computed from the current x/y/z and shift.
    always_comb begin
        xs_s         = x_r >>> shift_r;
        ys_s         = y_r >>> shift_r;
        e_s          = '0;
        dir_neg_s    = 1'b0;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        z_nxt_s      = z_r;
        hyp_repeat_s = 1'b0;

        // Rotation drives z to zero, vectoring drives y to zero.
        if (mode_r[0]) begin
            dir_neg_s = ~y_r[IW-1];
        end else begin
            dir_neg_s = z_r[IW-1];
        end

        case (mode_r[2:1])
            GEO_CIRC: e_s = e_circ_s[shift_r];
            GEO_LIN:  e_s = e_lin_s[shift_r];
            GEO_HYP:  e_s = e_hyp_s[shift_r];
            default:  e_s = '0;
        endcase

        if (dir_neg_s) begin
            y_nxt_s = y_r - xs_s;
            z_nxt_s = z_r + e_s;
        end else begin
            y_nxt_s = y_r + xs_s;
            z_nxt_s = z_r - e_s;
        end

        // x term carries mu: +1 circular, 0 linear, -1 hyperbolic.
        case (mode_r[2:1])
            GEO_CIRC: x_nxt_s = dir_neg_s ? (x_r + ys_s) : (x_r - ys_s);
            GEO_HYP:  x_nxt_s = dir_neg_s ? (x_r - ys_s) : (x_r + ys_s);
            default:  x_nxt_s = x_r;
        endcase

        // Hyperbolic convergence needs shifts 4 and 13 issued twice.
        if ((mode_r[2:1] == GEO_HYP) && !rep_r &&
            ((shift_r == 5'd4) || (shift_r == 5'd13))) begin
            hyp_repeat_s = 1'b1;
        end else begin
            hyp_repeat_s = 1'b0;
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mode_r    <= 3'd0;
            illegal_r <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            k_r       <= 5'd0;
            shift_r   <= 5'd0;
            rep_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r  <= mode;
                        x_r     <= IW'(x_in);
                        y_r     <= IW'(y_in);
                        z_r     <= IW'(z_in);
                        k_r     <= 5'd0;
                        rep_r   <= 1'b0;
                        shift_r <= (mode[2:1] == GEO_HYP) ? 5'd1 : 5'd0;
                        busy    <= 1'b1;
                        if (mode[2:1] == 2'b11) begin
                            illegal_r <= 1'b1;
                            state_r   <= FIN;
                        end else begin
                            illegal_r <= 1'b0;
                            state_r   <= RUN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    x_r <= x_nxt_s;
                    y_r <= y_nxt_s;
                    z_r <= z_nxt_s;
                    k_r <= k_r + 5'd1;
                    if (hyp_repeat_s) begin
                        rep_r <= 1'b1;
                    end else begin
                        rep_r   <= 1'b0;
                        shift_r <= shift_r + 5'd1;
                    end
                    if (k_r == 5'(ITER - 1)) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    err     <= illegal_r;
                    state_r <= IDLE;
                    if (illegal_r) begin
                        ovf   <= 1'b0;
                        x_out <= '0;
                        y_out <= '0;
                        z_out <= '0;
                    end else begin
                        ovf   <= out_of_range(x_r) | out_of_range(y_r) | out_of_range(z_r);
                        x_out <= saturate(x_r);
                        y_out <= saturate(y_r);
                        z_out <= saturate(z_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_param.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_param
// Directed bench for cordic_iter_param with default parameters
// (WIDTH=32, FRAC=16, ITER=16, GUARD=2). Expected values are hand-computed
// fixed-point results with the tolerances stated for each operation.
// -----------------------------------------------------------------------------
module tb_cordic_iter_param;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int ITER  = 16;
    localparam int GUARD = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [2:0]              mode;
    logic signed [WIDTH-1:0] x_in, y_in, z_in;
    logic                    busy, done, err, ovf;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;

    int n_checks = 0;
    int n_errors = 0;

    int shift4_cnt = 0;
    bit hs_on      = 1'b0;
    int hs_cyc     = 0;
    int hs_last    = -1;
    int hs_viol    = 0;
    int hs_dones   = 0;
    int hs_gaps[$];
    int lat;
    int late_dones;

    cordic_iter_param #(
        .WIDTH(WIDTH),
        .FRAC (FRAC),
        .ITER (ITER),
        .GUARD(GUARD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (mode),
        .x_in (x_in),
        .y_in (y_in),
        .z_in (z_in),
        .busy (busy),
        .done (done),
        .err  (err),
        .ovf  (ovf),
        .x_out(x_out),
        .y_out(y_out),
        .z_out(z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes the shift register and the start-held handshake run.
    always @(negedge clk) begin
        if (busy && !done && (dut.shift_r == 5'd4)) shift4_cnt++;
        if (hs_on) begin
            hs_cyc++;
            if (busy === done) hs_viol++;
            if (done) begin
                hs_dones++;
                if (hs_last >= 0) hs_gaps.push_back(hs_cyc - hs_last);
                hs_last = hs_cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp, input int tol);
        int diff;
        diff = $signed(obs) - $signed(exp);
        n_checks++;
        assert ((^obs !== 1'bx) && (diff <= tol) && (diff >= -tol)) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Issue one command and count edges after acceptance until done (0 = timeout).
    task automatic run_op(input logic [2:0] m, input logic [31:0] xi,
                          input logic [31:0] yi, input logic [31:0] zi, output int l);
        mode  = m;
        x_in  = xi;
        y_in  = yi;
        z_in  = zi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 3'd0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_flags", {30'd0, err, ovf}, 32'd0);
        check_eq("reset_x", x_out, 32'd0);
        check_eq("reset_y", y_out, 32'd0);
        check_eq("reset_z", z_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Circular rotation by pi/6 with 1/Kc preload.
        shift4_cnt = 0;
        run_op(3'd0, 32'h0000_9B75, 32'h0, 32'h0000_860B, lat);
        check_eq("circ_latency", lat, ITER + 1);
        check_near("circ_x", x_out, 32'h0000_DDB4, 8);
        check_near("circ_y", y_out, 32'h0000_8000, 8);
        check_near("circ_z", z_out, 32'h0, 8);
        check_eq("circ_flags", {30'd0, err, ovf}, 32'd0);
        check_eq("circ_shift4_once", shift4_cnt, 1);

        // Linear rotation: 2.0 * 1.5.
        run_op(3'd2, 32'h0002_0000, 32'h0, 32'h0001_8000, lat);
        check_eq("linrot_latency", lat, ITER + 1);
        check_near("linrot_y", y_out, 32'h0003_0000, 4);
        check_eq("linrot_x", x_out, 32'h0002_0000);
        check_eq("linrot_ovf", 32'(ovf), 32'd0);

        // Linear vectoring: 3.0 / 4.0.
        run_op(3'd3, 32'h0004_0000, 32'h0003_0000, 32'h0, lat);
        check_near("linvec_z", z_out, 32'h0000_C000, 4);
        check_near("linvec_y", y_out, 32'h0, 8);

        // Hyperbolic vectoring: atanh(0.5), shift 4 must repeat.
        shift4_cnt = 0;
        run_op(3'd5, 32'h0001_0000, 32'h0000_8000, 32'h0, lat);
        check_eq("hypvec_latency", lat, ITER + 1);
        check_near("hypvec_z", z_out, 32'h0000_8C9F, 8);
        check_eq("hypvec_shift4_twice", shift4_cnt, 2);

        // Illegal mode: immediate done with err and zeroed outputs.
        run_op(3'd6, 32'h1234_5678, 32'h0001_0000, 32'h0002_0000, lat);
        check_eq("illegal_latency", lat, 1);
        check_eq("illegal_err", 32'(err), 32'd1);
        check_eq("illegal_ovf", 32'(ovf), 32'd0);
        check_eq("illegal_x", x_out, 32'd0);
        check_eq("illegal_y", y_out, 32'd0);
        check_eq("illegal_z", z_out, 32'd0);

        // start held high: one done per ITER+2 cycles, busy low only with done.
        mode  = 3'd2;
        x_in  = 32'h0001_0000;
        y_in  = 32'h0;
        z_in  = 32'h0000_8000;
        start = 1'b1;
        @(posedge clk); #1;
        hs_on = 1'b1;
        repeat (3 * (ITER + 2)) @(posedge clk);
        #1;
        hs_on = 1'b0;
        start = 1'b0;
        repeat (ITER + 4) @(posedge clk);
        #1;
        check_eq("hs_done_count", hs_dones, 3);
        check_eq("hs_busy_viol", hs_viol, 0);
        for (int i = 0; i < hs_gaps.size(); i++) begin
            check_eq("hs_gap", hs_gaps[i], ITER + 2);
        end
        check_near("hs_y", y_out, 32'h0000_8000, 4);

        // Reset during RUN abandons the operation.
        mode  = 3'd0;
        x_in  = 32'h0000_9B75;
        y_in  = 32'h0;
        z_in  = 32'h0000_860B;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_y", y_out, 32'd0);
        check_eq("midrst_x", x_out, 32'd0);
        late_dones = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            @(posedge clk); #1;
            if (done) late_dones++;
        end
        check_eq("midrst_no_done", late_dones, 0);

        // New start after reset: linear rotation that saturates y.
        run_op(3'd2, 32'h7FFF_0000, 32'h0, 32'h0001_8000, lat);
        check_eq("ovf_latency", lat, ITER + 1);
        check_eq("ovf_y", y_out, 32'h7FFF_FFFF);
        check_eq("ovf_flag", 32'(ovf), 32'd1);
        check_eq("ovf_x", x_out, 32'h7FFF_0000);
        check_eq("ovf_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
